// File: rtl/mux_sched_pkg.sv
// Shared types and default sizing for the round-robin mux select scheduler.
package mux_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    localparam int unsigned N_SRC        = 10;
    localparam int unsigned SEL_W        = 4;
    localparam int unsigned MAX_HOLD_DEF = 16;

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Requester/consumer side of the scheduler: request vector, ack and the mux select/grant outputs.
interface mux_rr_scheduler_if #(
    parameter int unsigned N     = mux_sched_pkg::N_SRC,
    parameter int unsigned SEL_W = mux_sched_pkg::SEL_W
);
    logic [N-1:0]     req;
    logic             ack;
    logic [SEL_W-1:0] ss;
    logic [N-1:0]     gnt;
    logic             valid;
    logic             timeout;

    modport master (output req, ack, input ss, gnt, valid, timeout);
    modport slave  (input req, ack, output ss, gnt, valid, timeout);
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority search: first asserted req at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N     = mux_sched_pkg::N_SRC,
    parameter int unsigned SEL_W = mux_sched_pkg::SEL_W
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] win
);
    int unsigned idx;

    always_comb begin
        any = 1'b0;
        win = '0;
        idx = 0;
        for (int i = 0; i < int'(N); i++) begin
            idx = (32'(ptr) + 32'(i)) % N;
            if (!any && req[idx]) begin
                any = 1'b1;
                win = SEL_W'(idx);
            end
        end
    end
endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of a shared N:1 mux: registers the winner onto ss/gnt until ack or withdrawal.
// Optional grant timer enabled with `define ARB_TIMEOUT_EN (limit MAX_HOLD cycles).
module mux_rr_scheduler #(
    parameter int unsigned N        = mux_sched_pkg::N_SRC,
    parameter int unsigned SEL_W    = mux_sched_pkg::SEL_W,
    parameter int unsigned MAX_HOLD = mux_sched_pkg::MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mux_rr_scheduler_if.slave  bus
);
    import mux_sched_pkg::*;

    if (N < 2 || N > 16 || SEL_W < $clog2(N) || MAX_HOLD < 1) begin : g_bad_cfg
        $error("mux_rr_scheduler: unsupported parameter combination");
    end

    sched_state_t     state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ss_q;
    logic [N-1:0]     gnt_q;
    logic             valid_q;
    logic             pick_any;
    logic [SEL_W-1:0] pick_win;
    logic             owner_req_c;
    logic             release_c;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .any (pick_any),
        .win (pick_win)
    );

    // gnt_q is one-hot on the owner, so this is req[owner] without a variable index
    assign owner_req_c = |(bus.req & gnt_q);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;
    logic             expire_c;

    assign expire_c  = (hold_cnt == CNT_W'(MAX_HOLD));
    assign release_c = bus.ack || !owner_req_c || expire_c;
`else
    assign release_c = bus.ack || !owner_req_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            ss_q    <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state   <= GRANT;
                        ss_q    <= pick_win;
                        gnt_q   <= N'(1) << pick_win;
                        valid_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= CNT_W'(1);
`endif
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        state   <= GAP;
                        ss_q    <= '0;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        ptr     <= (ss_q == SEL_W'(N - 1)) ? '0 : ss_q + SEL_W'(1);
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= '0;
                        // ack in the expiry cycle is an ordinary release
                        timeout_q <= expire_c && !bus.ack;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
`endif
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ss    = ss_q;
    assign bus.gnt   = gnt_q;
    assign bus.valid = valid_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: vector tables plus hand-built multi-cycle sequences.
module tb_mux_rr_scheduler;
    localparam int unsigned NR = 10;
    localparam int unsigned SW = 4;
    localparam int unsigned MH = 16;

    typedef struct {
        string      tag;
        logic       valid;
        logic [3:0] ss;
        logic       to;
    } exp_t;

    typedef struct {
        string      tag;
        logic       rst;
        logic [9:0] req;
        logic       ack;
        logic       valid;
        logic [3:0] ss;
        logic       to;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    mux_rr_scheduler_if #(.N(NR), .SEL_W(SW)) bus ();

    mux_rr_scheduler #(.N(NR), .SEL_W(SW), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drive one cycle of inputs, queue the expected post-edge outputs, compare after the edge
    task automatic step(input string tag, input logic r, input logic [9:0] q, input logic a,
                        input logic ev, input logic [3:0] es, input logic et);
        exp_t       e;
        logic [9:0] egnt;
        rst     = r;
        bus.req = q;
        bus.ack = a;
        e = '{tag, ev, es, et};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e    = sb.pop_front();
        egnt = e.valid ? (10'd1 << e.ss) : 10'd0;
        checks++;
        if (bus.valid !== e.valid || bus.ss !== e.ss || bus.gnt !== egnt || bus.timeout !== e.to) begin
            errors++;
            $display("FAIL %s: got valid=%b ss=%0d gnt=%h timeout=%b, want valid=%b ss=%0d gnt=%h timeout=%b",
                     e.tag, bus.valid, bus.ss, bus.gnt, bus.timeout, e.valid, e.ss, egnt, e.to);
        end
    endtask

    function automatic void add(input string tag, input logic r, input logic [9:0] q, input logic a,
                                input logic ev, input logic [3:0] es);
        vec_t v;
        v = '{tag, r, q, a, ev, es, 1'b0};
        tbl.push_back(v);
    endfunction

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].tag, tbl[i].rst, tbl[i].req, tbl[i].ack, tbl[i].valid, tbl[i].ss, tbl[i].to);
        tbl.delete();
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        bus.ack = 1'b0;

        // Reset with all requests pending, then first grant one cycle after release
        add("rst_a",   1, 10'h3FF, 0, 0, 0);
        add("rst_b",   1, 10'h3FF, 0, 0, 0);
        add("first_g", 0, 10'h3FF, 0, 1, 0);
        add("hold_0",  0, 10'h3FF, 0, 1, 0);
        run_table();

        // Full round-robin rotation with one dead cycle between owners
        for (int k = 0; k < int'(NR); k++) begin
            step("rr_rel",  0, 10'h3FF, 1, 0, 0, 0);
            step("rr_gap",  0, 10'h3FF, 0, 0, 0, 0);
            step("rr_next", 0, 10'h3FF, 0, 1, 4'((k + 1) % NR), 0);
        end

        // Idle acks, sparse wrap, simultaneous ack+drop, withdrawal, reset mid-grant
        add("ack_rel",  0, 10'h3FF, 1, 0, 0);
        add("ack_gap",  0, 10'h000, 1, 0, 0);
        add("ack_idle", 0, 10'h000, 1, 0, 0);
        add("idle",     0, 10'h000, 0, 0, 0);
        add("g7",       0, 10'h080, 0, 1, 7);
        add("rel7",     0, 10'h080, 1, 0, 0);
        add("gap7",     0, 10'h204, 0, 0, 0);
        add("g9",       0, 10'h204, 0, 1, 9);
        add("rel9",     0, 10'h204, 1, 0, 0);
        add("gap9",     0, 10'h204, 0, 0, 0);
        add("g2_wrap",  0, 10'h204, 0, 1, 2);
        add("ack_drop", 0, 10'h200, 1, 0, 0);
        add("gap2",     0, 10'h200, 0, 0, 0);
        add("g9_once",  0, 10'h200, 0, 1, 9);
        add("wd9",      0, 10'h010, 0, 0, 0);
        add("gap9b",    0, 10'h010, 0, 0, 0);
        add("g4",       0, 10'h010, 0, 1, 4);
        add("hold4",    0, 10'h038, 0, 1, 4);
        add("wd4",      0, 10'h028, 0, 0, 0);
        add("gap4",     0, 10'h028, 0, 0, 0);
        add("g5_after", 0, 10'h028, 0, 1, 5);
        add("rst_mid",  1, 10'h028, 0, 0, 0);
        add("g3_ptr0",  0, 10'h028, 0, 1, 3);
        run_table();

`ifdef ARB_TIMEOUT_EN
        // Owner 3 never acks: revoked at the end of its 16th grant cycle
        for (int i = 2; i <= int'(MH); i++)
            step("to_hold", 0, 10'h018, 0, 1, 3, 0);
        step("to_fire",  0, 10'h018, 0, 0, 0, 1);
        step("to_gap",   0, 10'h018, 0, 0, 0, 0);
        step("to_next4", 0, 10'h018, 0, 1, 4, 0);
        // ack in the expiry cycle wins over the timer
        for (int i = 2; i <= int'(MH); i++)
            step("pre_hold", 0, 10'h018, 0, 1, 4, 0);
        step("ack_expiry", 0, 10'h018, 1, 0, 0, 0);
`else
        // Without the timer the grant survives arbitrarily long
        for (int i = 0; i < 100; i++)
            step("long_hold", 0, 10'h018, 0, 1, 3, 0);
        step("long_rel",  0, 10'h018, 1, 0, 0, 0);
        step("long_gap",  0, 10'h018, 0, 0, 0, 0);
        step("long_next", 0, 10'h018, 0, 1, 4, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
